// File: rtl/rpn_stack_calc_if.sv
// Front-end <-> calculator instruction and status bundle.
// master drives d/push/op/clr; slave returns out/cnt/err/full.
interface rpn_stack_calc_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] d;
  logic             push;
  logic [2:0]       op;
  logic             clr;
  logic [WIDTH-1:0] out;
  logic [CW-1:0]    cnt;
  logic             err;
  logic             full;

  modport master (
    output d, push, op, clr,
    input  out, cnt, err, full
  );

  modport slave (
    input  d, push, op, clr,
    output out, cnt, err, full
  );
endinterface

// File: rtl/rpn_stack_calc.sv
// RPN stack calculator: top-of-stack in a register, lower entries in RAM.
// Ports: step (clk), nrst (async low reset), bus (slave: d/push/op/clr in, out/cnt/err/full out).
module rpn_stack_calc #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024
) (
  input  logic step,
  input  logic nrst,
  rpn_stack_calc_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_NEG  = 3'd1,
    OP_ADD  = 3'd2,
    OP_MUL  = 3'd3,
    OP_SUB  = 3'd4,
    OP_DUP  = 3'd5,
    OP_DROP = 3'd6,
    OP_SWAP = 3'd7
  } op_e;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  logic [AW-1:0]    t_idx;
  logic [AW-1:0]    n_idx;
  logic [WIDTH-1:0] n_val;
  logic             ge1;
  logic             ge2;
  logic             is_full;

  // RAM slot cnt-1 is where T goes when pushed down; cnt-2 holds N.
  assign t_idx   = AW'(cnt_q - CW'(1));
  assign n_idx   = AW'(cnt_q - CW'(2));
  assign n_val   = mem[n_idx];
  assign ge1     = cnt_q != '0;
  assign ge2     = cnt_q >= CW'(2);
  assign is_full = cnt_q == CW'(DEPTH);

  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    err_d = err_q;
    we    = 1'b0;
    waddr = t_idx;
    wdata = out_q;
    if (bus.clr) begin
      out_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end else if (bus.push) begin
      if (is_full) begin
        err_d = 1'b1;
      end else begin
        we    = ge1;
        out_d = bus.d;
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      unique case (op_e'(bus.op))
        OP_NOP: begin
        end
        OP_NEG: begin
          if (ge1) out_d = -out_q;
          else     err_d = 1'b1;
        end
        OP_ADD: begin
          if (ge2) begin
            out_d = n_val + out_q;
            cnt_d = cnt_q - CW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        OP_MUL: begin
          if (ge2) begin
            out_d = n_val * out_q;
            cnt_d = cnt_q - CW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        OP_SUB: begin
          if (ge2) begin
            out_d = n_val - out_q;
            cnt_d = cnt_q - CW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        OP_DUP: begin
          if (!ge1 || is_full) begin
            err_d = 1'b1;
          end else begin
            we    = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
        end
        OP_DROP: begin
          if (ge1) begin
            out_d = ge2 ? n_val : '0;
            cnt_d = cnt_q - CW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        OP_SWAP: begin
          // Async read of old N and write of old T share this edge.
          if (ge2) begin
            we    = 1'b1;
            waddr = n_idx;
            out_d = n_val;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge step or negedge nrst) begin
    if (!nrst) begin
      out_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge step) begin
    if (we) mem[waddr] <= wdata;
  end

  assign bus.out  = out_q;
  assign bus.cnt  = cnt_q;
  assign bus.err  = err_q;
  assign bus.full = is_full;
endmodule

// File: tb/tb_rpn_stack_calc.sv
// Self-checking bench for rpn_stack_calc (WIDTH=16, DEPTH=4).
// Directed vector table, reset sequence, and random run against a queue model.
module tb_rpn_stack_calc;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic step;
  logic nrst;
  int   total;
  int   bad;

  rpn_stack_calc_if #(.WIDTH(W), .DEPTH(D)) bus ();

  rpn_stack_calc #(.WIDTH(W), .DEPTH(D)) dut (
    .step(step),
    .nrst(nrst),
    .bus (bus.slave)
  );

  initial step = 1'b0;
  always #5 step = ~step;

  typedef struct {
    logic          clr;
    logic          push;
    logic [2:0]    op;
    logic [W-1:0]  d;
    logic [W-1:0]  eo;
    logic [CW-1:0] ec;
    logic          ee;
    logic          ef;
  } vec_t;

  vec_t vq[$];

  logic [W-1:0] stk[$];
  logic         m_err;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic add(input logic c, input logic p, input logic [2:0] o,
                     input logic [W-1:0] dd, input logic [W-1:0] eo,
                     input int ec, input logic ee, input logic ef);
    vec_t v;
    v.clr = c; v.push = p; v.op = o; v.d = dd;
    v.eo = eo; v.ec = CW'(ec); v.ee = ee; v.ef = ef;
    vq.push_back(v);
  endtask

  task automatic drive(input logic c, input logic p, input logic [2:0] o,
                       input logic [W-1:0] dd);
    bus.clr  = c;
    bus.push = p;
    bus.op   = o;
    bus.d    = dd;
    @(posedge step);
    #1;
  endtask

  // Reference behaviour stated directly in stack terms.
  task automatic model(input logic c, input logic p, input logic [2:0] o,
                       input logic [W-1:0] dd);
    logic [W-1:0] t, n, r;
    int sz;
    sz = stk.size();
    if (c) begin
      stk.delete();
      m_err = 1'b0;
    end else if (p) begin
      if (sz == D) m_err = 1'b1;
      else         stk.push_back(dd);
    end else begin
      case (o)
        3'd0: ;
        3'd1: if (sz < 1) m_err = 1'b1;
              else begin t = stk.pop_back(); r = 0 - t; stk.push_back(r); end
        3'd2, 3'd3, 3'd4: begin
          if (sz < 2) m_err = 1'b1;
          else begin
            t = stk.pop_back();
            n = stk.pop_back();
            if (o == 3'd2)      r = n + t;
            else if (o == 3'd3) r = n * t;
            else                r = n - t;
            stk.push_back(r);
          end
        end
        3'd5: if (sz < 1 || sz == D) m_err = 1'b1;
              else stk.push_back(stk[sz-1]);
        3'd6: if (sz < 1) m_err = 1'b1;
              else void'(stk.pop_back());
        default: if (sz < 2) m_err = 1'b1;
              else begin
                t = stk.pop_back();
                n = stk.pop_back();
                stk.push_back(t);
                stk.push_back(n);
              end
      endcase
    end
  endtask

  function automatic int m_out();
    return (stk.size() > 0) ? int'(stk[stk.size()-1]) : 0;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    m_err = 1'b0;
    bus.clr = 0; bus.push = 0; bus.op = 0; bus.d = 0;
    nrst = 1'b0;
    #12;
    chk("rst_out", int'(bus.out), 0);
    chk("rst_cnt", int'(bus.cnt), 0);
    chk("rst_err", int'(bus.err), 0);
    @(negedge step);
    nrst = 1'b1;
    @(posedge step);
    #1;

    // T1: async reset mid-stream, no clock edge needed
    drive(0, 1, 0, 16'd11);
    drive(0, 1, 0, 16'd12);
    drive(0, 0, 3'd2, 0);
    drive(0, 1, 0, 16'd13);
    #2 nrst = 1'b0;
    #1;
    chk("t1_out", int'(bus.out), 0);
    chk("t1_cnt", int'(bus.cnt), 0);
    chk("t1_err", int'(bus.err), 0);
    @(negedge step);
    nrst = 1'b1;
    drive(0, 1, 0, 16'd5);
    chk("t1_push_out", int'(bus.out), 5);
    chk("t1_push_cnt", int'(bus.cnt), 1);
    drive(1, 0, 0, 0);

    // T2 arithmetic
    add(0,1,0,7,      7,1,0,0);
    add(0,1,0,3,      3,2,0,0);
    add(0,0,4,0,      4,1,0,0);
    add(0,1,0,300,    300,2,0,0);
    add(0,1,0,300,    300,3,0,0);
    add(0,0,3,0,      16'h5F90,2,0,0);
    add(1,0,0,0,      0,0,0,0);
    add(0,1,0,1,      1,1,0,0);
    add(0,0,1,0,      16'hFFFF,1,0,0);
    add(1,0,0,0,      0,0,0,0);
    // T3 stack ops
    add(0,1,0,1,      1,1,0,0);
    add(0,1,0,2,      2,2,0,0);
    add(0,1,0,3,      3,3,0,0);
    add(0,0,7,0,      2,3,0,0);
    add(0,0,6,0,      3,2,0,0);
    add(0,0,5,0,      3,3,0,0);
    add(0,0,2,0,      6,2,0,0);
    add(0,0,2,0,      7,1,0,0);
    add(1,0,0,0,      0,0,0,0);
    // T4 underflow
    add(0,0,2,0,      0,0,1,0);
    add(0,1,0,9,      9,1,1,0);
    add(0,0,4,0,      9,1,1,0);
    add(0,0,7,0,      9,1,1,0);
    add(0,0,6,0,      0,0,1,0);
    add(0,0,1,0,      0,0,1,0);
    add(1,0,0,0,      0,0,0,0);
    // T5 overflow
    add(0,1,0,1,      1,1,0,0);
    add(0,1,0,2,      2,2,0,0);
    add(0,1,0,3,      3,3,0,0);
    add(0,1,0,4,      4,4,0,1);
    add(0,1,0,5,      4,4,1,1);
    add(0,0,5,0,      4,4,1,1);
    add(0,0,0,0,      4,4,1,1);
    add(0,0,2,0,      7,3,1,0);
    add(0,0,2,0,      9,2,1,0);
    add(0,0,2,0,      10,1,1,0);
    // T6 priority
    add(1,1,0,8,      0,0,0,0);
    add(0,1,2,2,      2,1,0,0);
    add(0,1,2,5,      5,2,0,0);
    add(0,0,3,0,      10,1,0,0);
    add(1,0,0,0,      0,0,0,0);

    foreach (vq[i]) begin
      drive(vq[i].clr, vq[i].push, vq[i].op, vq[i].d);
      chk($sformatf("vec%0d_out", i),  int'(bus.out),  int'(vq[i].eo));
      chk($sformatf("vec%0d_cnt", i),  int'(bus.cnt),  int'(vq[i].ec));
      chk($sformatf("vec%0d_err", i),  int'(bus.err),  int'(vq[i].ee));
      chk($sformatf("vec%0d_full", i), int'(bus.full), int'(vq[i].ef));
    end

    // Random run against the queue model
    stk.delete();
    m_err = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic c, p;
      logic [2:0] o;
      logic [W-1:0] dd;
      c  = ($urandom_range(0, 39) == 0);
      p  = ($urandom_range(0, 9) < 4);
      o  = 3'($urandom_range(0, 7));
      dd = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      drive(c, p, o, dd);
      model(c, p, o, dd);
      chk("rnd_out",  int'(bus.out),  m_out());
      chk("rnd_cnt",  int'(bus.cnt),  stk.size());
      chk("rnd_err",  int'(bus.err),  int'(m_err));
      chk("rnd_full", int'(bus.full), int'(stk.size() == D));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
